// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one single-port SRAM
//   macro. Each grant owns the macro for exactly one read or write burst of
//   len+1 consecutive words starting at the requester's byte address.
//
// Ports
//   ACLK, ARESETn          clock (rising edge) and synchronous active-low reset
//   req/req_we/req_addr/   per-requester burst request: held until gnt, direction,
//   req_len                byte start address, beats-1
//   gnt                    one-cycle one-hot grant pulse
//   wdata/wstrb/wvalid     per-requester write beat; accepted when wvalid&wready
//   wready                 asserted to the owner for the whole write phase
//   rdata/rvalid/rlast     shared read data, per-requester valid, last-beat flag
//   done                   one-cycle pulse to the owner when a write burst ends
//   CS/OE/WEB/A/DI/DO      SRAM macro pins (WEB active-low per byte, DO one cycle
//                          after the address with OE=1)
module sram_port_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int LEN_BITS = 4
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*32-1:0]       req_addr,
  input  logic [NUM_REQ*LEN_BITS-1:0] req_len,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic [NUM_REQ*32-1:0]       wdata,
  input  logic [NUM_REQ*4-1:0]        wstrb,
  input  logic [NUM_REQ-1:0]          wvalid,
  output logic [NUM_REQ-1:0]          wready,
  output logic [31:0]                 rdata,
  output logic [NUM_REQ-1:0]          rvalid,
  output logic                        rlast,
  output logic [NUM_REQ-1:0]          done,
  output logic                        CS,
  output logic                        OE,
  output logic [3:0]                  WEB,
  output logic [13:0]                 A,
  output logic [31:0]                 DI,
  input  logic [31:0]                 DO
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    RD,
    RD_DRAIN,
    WR,
    WR_DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     pick;
  logic [IDX_W-1:0]     cand;
  logic                 pick_ok;
  logic                 we_q;
  logic [13:0]          base_q;
  logic [LEN_BITS-1:0]  len_q;
  // One bit wider than len so that len = 2^LEN_BITS-1 never wraps the counter.
  logic [LEN_BITS:0]    beat;
  logic                 last_beat;
  logic [13:0]          beat_addr;
  logic [IDX_W-1:0]     owner_inc;
  logic                 unused_addr_bits;

  // Only word address bits [15:2] reach the macro.
  assign unused_addr_bits = ^req_addr;

  assign CS        = 1'b1;
  assign rdata     = DO;
  assign last_beat = (beat == {1'b0, len_q});
  assign beat_addr = base_q + 14'(beat);
  assign owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // Round-robin pick: first asserted request at or after rr_ptr, wrapping.
  always_comb begin
    pick    = '0;
    cand    = '0;
    pick_ok = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!pick_ok && req[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  // ---- control state: FSM, round-robin pointer, beat counter ----
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state  <= IDLE;
      rr_ptr <= '0;
      beat   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        GRANT: begin
          beat   <= '0;
          rr_ptr <= owner_inc;
        end
        RD:      beat <= beat + 1'b1;
        WR:      if (wvalid[owner]) beat <= beat + 1'b1;
        default: ;
      endcase
    end
  end

  // ---- burst descriptor, captured once in IDLE so later changes are ignored ----
  always_ff @(posedge ACLK) begin
    if (state == IDLE && pick_ok) begin
      owner  <= pick;
      we_q   <= req_we[pick];
      base_q <= req_addr[32*int'(pick) + 2 +: 14];
      len_q  <= req_len[LEN_BITS*int'(pick) +: LEN_BITS];
    end
  end

  // ---- next state and macro/requester outputs ----
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    wready    = '0;
    rvalid    = '0;
    done      = '0;
    rlast     = 1'b0;
    OE        = 1'b0;
    WEB       = 4'hF;
    A         = '0;
    DI        = '0;
    case (state)
      IDLE: begin
        if (pick_ok) state_nxt = GRANT;
      end
      GRANT: begin
        gnt[owner] = 1'b1;
        state_nxt  = we_q ? WR : RD;
      end
      RD: begin
        OE = 1'b1;
        A  = beat_addr;
        // Data for the previous cycle's address arrives now.
        if (beat != '0) rvalid[owner] = 1'b1;
        if (last_beat) state_nxt = RD_DRAIN;
      end
      RD_DRAIN: begin
        rvalid[owner] = 1'b1;
        rlast         = 1'b1;
        state_nxt     = IDLE;
      end
      WR: begin
        wready[owner] = 1'b1;
        if (wvalid[owner]) begin
          A   = beat_addr;
          DI  = wdata[32*int'(owner) +: 32];
          WEB = ~wstrb[4*int'(owner) +: 4];
          if (last_beat) state_nxt = WR_DONE;
        end
      end
      WR_DONE: begin
        done[owner] = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
